// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the operand sequencer and its shifter.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 6;

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    EXEC  = 2'd2,
    HOLD  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_sra.sv
// Combinational arithmetic right shift: s = a >>> b, b unsigned over its full width.
import alu_pkg::*;

module alu_sra #(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s
);

  logic signed [WIDTH-1:0] w_a_signed;

  assign w_a_signed = $signed(a);

  // The shift amount is not truncated, so any b >= WIDTH fills every bit with the sign.
  assign s = w_a_signed >>> b;

endmodule

// File: rtl/operand_sequencer.sv
// Collects operands a then b, returns the registered a >>> b through a valid/ready handshake.
// Optional result flags (out_zero, out_neg) are built when ALU_SEQ_FLAGS_EN is defined.
import alu_pkg::*;

module operand_sequencer #(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg
`endif
);

  seq_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [WIDTH-1:0] w_shift;
  logic             w_in_xfer;
  logic             w_out_xfer;
`ifdef ALU_SEQ_FLAGS_EN
  logic             r_out_zero;
  logic             r_out_neg;
`endif

  alu_sra #(
    .WIDTH (WIDTH)
  ) u_alu_sra (
    .a (r_a),
    .b (r_b),
    .s (w_shift)
  );

  assign in_ready   = (r_state == GET_A) || (r_state == GET_B);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= GET_A;
      r_a         <= '0;
      r_b         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      r_out_zero  <= 1'b0;
      r_out_neg   <= 1'b0;
`endif
    end else begin
      case (r_state)
        GET_A: begin
          if (w_in_xfer) begin
            r_a     <= in_data;
            r_state <= GET_B;
          end
        end
        GET_B: begin
          if (w_in_xfer) begin
            r_b     <= in_data;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_out_data  <= w_shift;
          r_out_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
          r_out_zero  <= (w_shift == '0);
          r_out_neg   <= w_shift[WIDTH-1];
`endif
          r_state     <= HOLD;
        end
        HOLD: begin
          // Result and flags stay frozen until the consumer takes them.
          if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_state     <= GET_A;
          end
        end
        default: r_state <= GET_A;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
`ifdef ALU_SEQ_FLAGS_EN
  assign out_zero  = r_out_zero;
  assign out_neg   = r_out_neg;
`endif

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 6, the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port in_data, input, WIDTH, the operand word; the first accepted word is a, the second is b.
REQ-005 SHALL have port in_valid, input, 1, meaning in_data is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-007 SHALL have port out_data, output, WIDTH, the registered result a >>> b (arithmetic right shift).
REQ-008 SHALL have port out_valid, output, 1, meaning out_data is valid.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer accepts out_data.
REQ-010 SHALL have ports out_zero and out_neg, output, 1 each, the result flags; they exist only when ALU_SEQ_FLAGS_EN is defined.

Function
REQ-011 SHALL implement four states: GET_A, GET_B, EXEC and HOLD.
REQ-012 SHALL define a transfer as in_valid && in_ready on an input edge, or out_valid && out_ready on an output edge.
REQ-013 SHALL assert in_ready only in GET_A and GET_B, and only combinationally from state.
REQ-014 SHALL, in GET_A: on an input transfer, latch a and move to GET_B; otherwise stay.
REQ-015 SHALL, in GET_B: on an input transfer, latch b and move to EXEC; otherwise stay.
REQ-016 SHALL, in EXEC: register the shifter output into out_data, set out_valid and move to HOLD; exactly one cycle, unconditional.
REQ-017 SHALL, in HOLD: keep out_data and out_valid stable until an output transfer, then clear out_valid and return to GET_A.
REQ-018 SHALL produce out_valid on the 2nd rising edge after the b transfer edge (the EXEC edge plus the capture edge).
REQ-019 SHALL use the shift rule: result = a shifted right by b with sign-bit fill; b >= WIDTH gives all bits equal to a[WIDTH-1]; b = 0 gives a.
REQ-020 SHALL treat b as unsigned, using all WIDTH bits of it, with no truncation to log2(WIDTH).
REQ-021 SHALL accept no new operand while in EXEC or HOLD; the upstream stalls.
REQ-022 SHALL NOT make out_valid depend combinationally on out_ready.
REQ-023 SHALL ignore in_data and in_valid when in_ready is low.

Reset
REQ-024 SHALL, on rst high, immediately force: state GET_A, a=0, b=0, out_data=0, out_valid=0, out_zero=0, out_neg=0.
REQ-025 SHALL, on rst asserted mid-operation (any state), abandon the partial operand or held result without producing output.
REQ-026 SHALL, on the first rising edge after rst deasserts, be able to accept the a operand.

Configuration
REQ-027 SHALL, with ALU_SEQ_FLAGS_EN defined, register out_zero = (result == 0) and out_neg = result[WIDTH-1] in the same EXEC edge as out_data, held with it.
REQ-028 SHALL, with ALU_SEQ_FLAGS_EN undefined, not have the flag ports or flag registers; all other behaviour is identical.

Structure
REQ-029 SHALL take the state encoding (GET_A=0, GET_B=1, EXEC=2, HOLD=3) and the default WIDTH constant from the shared alu_pkg package.
REQ-030 SHALL place the combinational arithmetic shifter in sub-module alu_sra, parameterised by WIDTH, with ports a, b and s, instantiated once.
REQ-031 SHALL keep all registers in operand_sequencer; alu_sra is purely combinational.

Verification
REQ-032 SHALL cover: reset, then a=32 then b=3, out_ready=1 -> out_data=60 (111100), out_valid for 1 cycle, out_neg=1, out_zero=0.
REQ-033 SHALL cover: a=20, b=0 -> out_data=20; then a=20, b=9 -> out_data=0, out_zero=1.
REQ-034 SHALL cover: a=33, b=63 -> out_data=63 (sign fill at maximum shift).
REQ-035 SHALL cover: result ready with out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> return to GET_A.
REQ-036 SHALL cover: rst pulsed in GET_B after a=12 accepted -> out_valid stays 0; next a=8, b=1 -> out_data=4.
REQ-037 SHALL cover: in_valid toggling with gaps between a and b -> the same result as back-to-back input, latency 2 edges after the b transfer.
